wb_scoreboard: RTL

- In-order completion buffer directly downstream of the writeback stage.
- Allocates a scoreboard id (sid) per issued instruction and captures writeback results (rd, value) by sid.
- Retires up to two completed instructions per cycle, in program order, to the register file write ports.
- Sid format: entry index plus one wrap bit, matching the sid carried through the writeback stage.

---
 rtl/wb_scoreboard.sv | 132 +++++++++++++
 1 files changed

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: in-order completion buffer after writeback, retiring up to two results per cycle.
// Optional define SCOREBOARD_PERF_CNT_EN adds the retire_cnt_o retirement counter.
module wb_scoreboard #(
    parameter int SB_DEPTH_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  alloc0_valid_i,
    input  logic [4:0]            alloc0_rd_i,
    input  logic                  alloc1_valid_i,
    input  logic [4:0]            alloc1_rd_i,
    output logic                  alloc_ready_o,
    output logic [SB_DEPTH_W:0]   alloc0_sid_o,
    output logic [SB_DEPTH_W:0]   alloc1_sid_o,
    input  logic                  wb0_valid_i,
    input  logic [SB_DEPTH_W:0]   wb0_sid_i,
    input  logic [63:0]           wb0_value_i,
    input  logic                  wb1_valid_i,
    input  logic [SB_DEPTH_W:0]   wb1_sid_i,
    input  logic [63:0]           wb1_value_i,
    output logic                  retire0_valid_o,
    output logic                  retire0_we_o,
    output logic [4:0]            retire0_rd_o,
    output logic [63:0]           retire0_value_o,
    output logic                  retire1_valid_o,
    output logic                  retire1_we_o,
    output logic [4:0]            retire1_rd_o,
    output logic [63:0]           retire1_value_o,
    output logic                  sb_empty_o
`ifdef SCOREBOARD_PERF_CNT_EN
    ,
    output logic [63:0]           retire_cnt_o
`endif
);
    localparam int DEPTH = 1 << SB_DEPTH_W;
    localparam int PW = SB_DEPTH_W + 1;
    logic [PW-1:0] head, tail, head1, tail1, count;
    logic [DEPTH-1:0] occ, done, wrap;
    logic [4:0] rd_q [DEPTH];
    logic [63:0] val_q [DEPTH];
    logic [SB_DEPTH_W-1:0] hi0, hi1, ti0, ti1, wi0, wi1;
    logic a0, a1, r0, r1, m0, m1;
    assign count = tail - head;
    assign alloc_ready_o = count <= PW'(DEPTH - 2);
    assign sb_empty_o = count == '0;
    assign a0 = alloc0_valid_i && alloc_ready_o;
    assign a1 = alloc1_valid_i && alloc_ready_o;
    assign alloc0_sid_o = tail;
    assign alloc1_sid_o = tail + PW'(alloc0_valid_i);
    assign tail1 = tail + PW'(a0);
    assign head1 = head + PW'(1);
    assign hi0 = head[SB_DEPTH_W-1:0];
    assign hi1 = head1[SB_DEPTH_W-1:0];
    assign ti0 = tail[SB_DEPTH_W-1:0];
    assign ti1 = tail1[SB_DEPTH_W-1:0];
    assign wi0 = wb0_sid_i[SB_DEPTH_W-1:0];
    assign wi1 = wb1_sid_i[SB_DEPTH_W-1:0];
    // the wrap bit rejects stale sids that alias a reused index
    assign m0 = wb0_valid_i && occ[wi0] && (wrap[wi0] == wb0_sid_i[PW-1]);
    assign m1 = wb1_valid_i && occ[wi1] && (wrap[wi1] == wb1_sid_i[PW-1]);
    assign r0 = occ[hi0] && done[hi0];
    assign r1 = r0 && occ[hi1] && done[hi1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ <= '0;
            done <= '0;
            wrap <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
                val_q[i] <= '0;
            end
            {retire0_valid_o, retire0_we_o, retire0_rd_o, retire0_value_o} <= '0;
            {retire1_valid_o, retire1_we_o, retire1_rd_o, retire1_value_o} <= '0;
        end else if (flush_i) begin
            head <= '0;
            tail <= '0;
            occ <= '0;
            done <= '0;
            {retire0_valid_o, retire0_we_o, retire0_rd_o, retire0_value_o} <= '0;
            {retire1_valid_o, retire1_we_o, retire1_rd_o, retire1_value_o} <= '0;
        end else begin
            if (m0) begin
                done[wi0] <= 1'b1;
                val_q[wi0] <= wb0_value_i;
            end
            if (m1) begin
                done[wi1] <= 1'b1;
                val_q[wi1] <= wb1_value_i;
            end
            retire0_valid_o <= r0;
            retire0_we_o <= r0 && (rd_q[hi0] != '0);
            retire0_rd_o <= r0 ? rd_q[hi0] : '0;
            retire0_value_o <= r0 ? val_q[hi0] : '0;
            retire1_valid_o <= r1;
            retire1_we_o <= r1 && (rd_q[hi1] != '0);
            retire1_rd_o <= r1 ? rd_q[hi1] : '0;
            retire1_value_o <= r1 ? val_q[hi1] : '0;
            // retire clears come after completion updates so they win on the same entry
            if (r0) begin
                occ[hi0] <= 1'b0;
                done[hi0] <= 1'b0;
            end
            if (r1) begin
                occ[hi1] <= 1'b0;
                done[hi1] <= 1'b0;
            end
            head <= head + PW'(r0) + PW'(r1);
            if (a0) begin
                occ[ti0] <= 1'b1;
                done[ti0] <= 1'b0;
                rd_q[ti0] <= alloc0_rd_i;
                wrap[ti0] <= tail[PW-1];
            end
            if (a1) begin
                occ[ti1] <= 1'b1;
                done[ti1] <= 1'b0;
                rd_q[ti1] <= alloc1_rd_i;
                wrap[ti1] <= tail1[PW-1];
            end
            tail <= tail + PW'(a0) + PW'(a1);
        end
    end
`ifdef SCOREBOARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retire_cnt_o <= '0;
        else retire_cnt_o <= retire_cnt_o + 64'(retire0_valid_o) + 64'(retire1_valid_o);
    end
`endif
endmodule
